decode_regfile: RTL

Architectural register file for the pipelined RISC-V core, with the decode-to-execute read boundary. It accepts the result committed by the writeback stage and serves the two source-operand reads of the decode stage. Read data, source indices and a valid flag are captured into execute-stage registers. Stall and flush controls come from the hazard unit.

---
 rtl/decode_regfile_if.sv | 30 +++
 rtl/decode_regfile.sv | 57 +++++
 2 files changed

// File: rtl/decode_regfile_if.sv
// decode_regfile_if: writeback write port, decode read/control inputs and execute-stage outputs
// of the decode register file. master drives the pipeline side; slave is the register file.
interface decode_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWriteW;
  logic [ADDR_W-1:0] RDW;
  logic [DATA_W-1:0] ResultW;
  logic [ADDR_W-1:0] A1D;
  logic [ADDR_W-1:0] A2D;
  logic              ValidD;
  logic              EnD;
  logic              FlushE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [ADDR_W-1:0] RS1E;
  logic [ADDR_W-1:0] RS2E;
  logic              ValidE;

  modport master (
    output RegWriteW, RDW, ResultW, A1D, A2D, ValidD, EnD, FlushE,
    input  RD1E, RD2E, RS1E, RS2E, ValidE
  );

  modport slave (
    input  RegWriteW, RDW, ResultW, A1D, A2D, ValidD, EnD, FlushE,
    output RD1E, RD2E, RS1E, RS2E, ValidE
  );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: architectural register file with a registered decode-to-execute read boundary.
// Define REGFILE_BYPASS_EN to forward a same-edge writeback into the captured operands.
module decode_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic             clk,
  input logic             rst,
  decode_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;
  logic              wr_ok;

  // x0 and indices beyond NREG never commit
  assign wr_ok = bus.RegWriteW && (bus.RDW != '0) && (32'(bus.RDW) < NREG);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.RDW] <= bus.ResultW;
    end
  end

  always_comb begin
    rd1_next = '0;
    rd2_next = '0;
    if ((bus.A1D != '0) && (32'(bus.A1D) < NREG)) rd1_next = regs[bus.A1D];
    if ((bus.A2D != '0) && (32'(bus.A2D) < NREG)) rd2_next = regs[bus.A2D];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.RDW == bus.A1D)) rd1_next = bus.ResultW;
    if (wr_ok && (bus.RDW == bus.A2D)) rd2_next = bus.ResultW;
`endif
  end

  // Reset beats flush, flush beats stall; a stall leaves every execute register untouched
  always_ff @(posedge clk) begin
    if (!rst || bus.FlushE) begin
      bus.RD1E   <= '0;
      bus.RD2E   <= '0;
      bus.RS1E   <= '0;
      bus.RS2E   <= '0;
      bus.ValidE <= 1'b0;
    end else if (bus.EnD) begin
      bus.RD1E   <= rd1_next;
      bus.RD2E   <= rd2_next;
      bus.RS1E   <= bus.A1D;
      bus.RS2E   <= bus.A2D;
      bus.ValidE <= bus.ValidD;
    end
  end

endmodule
